// File: rtl/sadd_pipe.sv
// Pipelined signed adder/accumulator with optional saturation.
// Stage 1 adds and clips; the remaining stages only delay the result and its flags.
module sadd_pipe #(
    parameter int unsigned DATAWIDTH = 8,
    parameter int unsigned LATENCY   = 2,
    parameter bit          SATURATE  = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATAWIDTH-1:0] a,
    input  logic [DATAWIDTH-1:0] b,
    input  logic                 mode,
    input  logic                 clr,
    input  logic                 in_valid,
    output logic [DATAWIDTH-1:0] sum,
    output logic                 out_valid,
    output logic                 ovf,
    output logic                 ovf_sticky
);

    localparam int unsigned W = DATAWIDTH;
    localparam logic [W-1:0] MAX_V = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] MIN_V = {1'b1, {(W-1){1'b0}}};

    logic [W-1:0]       acc_q, acc_d;
    logic               sticky_q, sticky_d;
    logic [W-1:0]       op_x, op_y, s1_res;
    logic [W:0]         s1_full;
    logic               s1_ovf;

    logic [W-1:0]       dat_q  [LATENCY];
    logic [W-1:0]       dat_in [LATENCY];
    logic [LATENCY-1:0] vld_q, ovf_q;
    logic [LATENCY-1:0] vld_in, ovf_in;

    // Stage-1 operand select, full-precision add and clip
    always_comb begin
        op_x = a;
        op_y = b;
        if (mode) begin
            op_x = clr ? '0 : acc_q;
            op_y = a;
        end
        s1_full = {op_x[W-1], op_x} + {op_y[W-1], op_y};
        s1_ovf  = s1_full[W] ^ s1_full[W-1];
        s1_res  = s1_full[W-1:0];
        if (SATURATE && s1_ovf) begin
            s1_res = s1_full[W] ? MIN_V : MAX_V;
        end
    end

    // Accumulator takes the clipped result so feedback is single-cycle
    always_comb begin
        acc_d = acc_q;
        if (in_valid && mode) begin
            acc_d = s1_res;
        end else if (clr) begin
            acc_d = '0;
        end
    end

    // Per-stage inputs: stage 0 from the adder, stage k from stage k-1
    always_comb begin
        dat_in[0] = s1_res;
        vld_in[0] = in_valid;
        ovf_in[0] = s1_ovf;
        for (int k = 1; k < int'(LATENCY); k++) begin
            dat_in[k] = dat_q[k-1];
            vld_in[k] = vld_q[k-1];
            ovf_in[k] = ovf_q[k-1];
        end
    end

    // Sticky rises together with the ovf it records; clr wins
    always_comb begin
        sticky_d = sticky_q;
        if (clr) begin
            sticky_d = 1'b0;
        end else if (vld_in[LATENCY-1] && ovf_in[LATENCY-1]) begin
            sticky_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q    <= '0;
            sticky_q <= 1'b0;
            vld_q    <= '0;
            ovf_q    <= '0;
            for (int k = 0; k < int'(LATENCY); k++) begin
                dat_q[k] <= '0;
            end
        end else begin
            acc_q    <= acc_d;
            sticky_q <= sticky_d;
            for (int k = 0; k < int'(LATENCY); k++) begin
                vld_q[k] <= vld_in[k];
                if (vld_in[k]) begin
                    dat_q[k] <= dat_in[k];
                    ovf_q[k] <= ovf_in[k];
                end
            end
        end
    end

    assign sum        = dat_q[LATENCY-1];
    assign out_valid  = vld_q[LATENCY-1];
    assign ovf        = ovf_q[LATENCY-1];
    assign ovf_sticky = sticky_q;

endmodule

// File: tb/tb_sadd_pipe.sv
// Directed bench for sadd_pipe: saturating and wrapping instances share stimulus.
module tb_sadd_pipe;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic signed [7:0] a = '0, b = '0;
    logic              mode = 1'b0, clr = 1'b0, in_valid = 1'b0;
    logic [7:0]        sum_s, sum_w;
    logic              vld_s, vld_w, ovf_s, ovf_w, stk_s, stk_w;

    int n_run  = 0;
    int n_fail = 0;

    sadd_pipe #(.DATAWIDTH(8), .LATENCY(2), .SATURATE(1'b1)) dut (
        .clk(clk), .rst(rst), .a(a), .b(b), .mode(mode), .clr(clr),
        .in_valid(in_valid), .sum(sum_s), .out_valid(vld_s), .ovf(ovf_s),
        .ovf_sticky(stk_s)
    );

    sadd_pipe #(.DATAWIDTH(8), .LATENCY(2), .SATURATE(1'b0)) dut_w (
        .clk(clk), .rst(rst), .a(a), .b(b), .mode(mode), .clr(clr),
        .in_valid(in_valid), .sum(sum_w), .out_valid(vld_w), .ovf(ovf_w),
        .ovf_sticky(stk_w)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic signed [7:0] a;
        logic signed [7:0] b;
        int                exp_sat;
        int                exp_wrap;
        int                exp_ovf;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string nm, input int act, input int exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic m, input logic c,
                         input int av, input int bv);
        in_valid = v;
        mode     = m;
        clr      = c;
        a        = 8'(av);
        b        = 8'(bv);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vecs[0] = '{a: 8'sd100,  b: 8'sd27,   exp_sat: 127,  exp_wrap: 127,  exp_ovf: 0};
        vecs[1] = '{a: 8'sd100,  b: 8'sd28,   exp_sat: 127,  exp_wrap: -128, exp_ovf: 1};
        vecs[2] = '{a: -8'sd100, b: -8'sd28,  exp_sat: -128, exp_wrap: -128, exp_ovf: 0};
        vecs[3] = '{a: -8'sd100, b: -8'sd29,  exp_sat: -128, exp_wrap: 127,  exp_ovf: 1};
        vecs[4] = '{a: 8'sd0,    b: 8'sd0,    exp_sat: 0,    exp_wrap: 0,    exp_ovf: 0};
        vecs[5] = '{a: -8'sd1,   b: 8'sd1,    exp_sat: 0,    exp_wrap: 0,    exp_ovf: 0};
        vecs[6] = '{a: 8'sd127,  b: 8'sd127,  exp_sat: 127,  exp_wrap: -2,   exp_ovf: 1};
        vecs[7] = '{a: -8'sd128, b: -8'sd128, exp_sat: -128, exp_wrap: 0,    exp_ovf: 1};
        vecs[8] = '{a: 8'sd5,    b: -8'sd3,   exp_sat: 2,    exp_wrap: 2,    exp_ovf: 0};

        // Reset state
        tick();
        tick();
        chk("rst_sum", int'($signed(sum_s)), 0);
        chk("rst_valid", int'(vld_s), 0);
        chk("rst_ovf", int'(ovf_s), 0);
        chk("rst_sticky", int'(stk_s), 0);
        rst = 1'b0;
        tick();

        // Isolated add-mode vectors, both clip policies
        for (int i = 0; i < 9; i++) begin
            drive(1'b1, 1'b0, 1'b0, int'(vecs[i].a), int'(vecs[i].b));
            tick();
            drive(1'b0, 1'b0, 1'b0, 0, 0);
            tick();
            chk($sformatf("add%0d_valid", i), int'(vld_s), 1);
            chk($sformatf("add%0d_sat", i), int'($signed(sum_s)), vecs[i].exp_sat);
            chk($sformatf("add%0d_ovf", i), int'(ovf_s), vecs[i].exp_ovf);
            chk($sformatf("add%0d_wrap", i), int'($signed(sum_w)), vecs[i].exp_wrap);
            chk($sformatf("add%0d_wovf", i), int'(ovf_w), vecs[i].exp_ovf);
            if (i == 3) chk("neg_sticky", int'(stk_s), 1);
        end

        // clr alone drops the sticky flag
        chk("sticky_before_clr", int'(stk_s), 1);
        drive(1'b0, 1'b0, 1'b1, 0, 0);
        tick();
        drive(1'b0, 1'b0, 1'b0, 0, 0);
        chk("sticky_after_clr", int'(stk_s), 0);
        tick();

        // Back-to-back accumulate of 10
        for (int cyc = 0; cyc < 7; cyc++) begin
            if (cyc < 5) drive(1'b1, 1'b1, 1'b0, 10, 0);
            else         drive(1'b0, 1'b0, 1'b0, 0, 0);
            tick();
            if (cyc >= 1 && cyc <= 5) begin
                chk($sformatf("acc%0d_valid", cyc), int'(vld_s), 1);
                chk($sformatf("acc%0d_sum", cyc), int'($signed(sum_s)), 10 * cyc);
            end
        end
        chk("acc_tail_valid", int'(vld_s), 0);
        chk("acc_tail_hold", int'($signed(sum_s)), 50);

        // Accumulator saturation: clr-seeded 120, +10, -7
        drive(1'b1, 1'b1, 1'b1, 120, 0);
        tick();
        drive(1'b1, 1'b1, 1'b0, 10, 0);
        tick();
        chk("accsat_seed", int'($signed(sum_s)), 120);
        chk("accsat_seed_ovf", int'(ovf_s), 0);
        drive(1'b1, 1'b1, 1'b0, -7, 0);
        tick();
        chk("accsat_clip", int'($signed(sum_s)), 127);
        chk("accsat_ovf", int'(ovf_s), 1);
        chk("accsat_sticky", int'(stk_s), 1);
        chk("accsat_wrap", int'($signed(sum_w)), -126);
        drive(1'b0, 1'b0, 1'b0, 0, 0);
        tick();
        chk("accsat_back", int'($signed(sum_s)), 120);
        chk("accsat_back_ovf", int'(ovf_s), 0);
        chk("accsat_sticky_hold", int'(stk_s), 1);
        drive(1'b0, 1'b0, 1'b1, 0, 0);
        tick();
        chk("accsat_sticky_clr", int'(stk_s), 0);
        drive(1'b1, 1'b1, 1'b0, 3, 0);
        tick();
        drive(1'b0, 1'b0, 1'b0, 0, 0);
        tick();
        chk("acc_after_clr", int'($signed(sum_s)), 3);

        // clr with add mode clears acc while adding normally
        drive(1'b1, 1'b0, 1'b1, 1, 2);
        tick();
        drive(1'b1, 1'b1, 1'b0, 4, 0);
        tick();
        chk("clradd_sum", int'($signed(sum_s)), 3);
        drive(1'b0, 1'b0, 1'b0, 0, 0);
        tick();
        chk("clradd_acc", int'($signed(sum_s)), 4);

        // Bubble pattern 1,0,1,1
        begin
            logic pv [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
            int   pa [4] = '{1, 50, 3, 4};
            int   ev [4] = '{1, 0, 1, 1};
            int   es [4] = '{2, 2, 6, 8};
            for (int cyc = 0; cyc < 6; cyc++) begin
                if (cyc < 4) drive(pv[cyc], 1'b0, 1'b0, pa[cyc], pa[cyc]);
                else         drive(1'b0, 1'b0, 1'b0, 0, 0);
                tick();
                if (cyc >= 1 && cyc <= 4) begin
                    chk($sformatf("bub%0d_valid", cyc), int'(vld_s), ev[cyc-1]);
                    chk($sformatf("bub%0d_sum", cyc), int'($signed(sum_s)), es[cyc-1]);
                end
            end
        end

        // Reset between edges with two transactions in flight
        drive(1'b1, 1'b1, 1'b0, 9, 0);
        tick();
        tick();
        chk("mid_inflight", int'(vld_s), 1);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_sum", int'($signed(sum_s)), 0);
        chk("mid_valid", int'(vld_s), 0);
        chk("mid_acc", int'($signed(dut.acc_q)), 0);
        drive(1'b0, 1'b0, 1'b0, 0, 0);
        #1;
        rst = 1'b0;
        for (int cyc = 0; cyc < 3; cyc++) begin
            tick();
            chk($sformatf("post_rst%0d_valid", cyc), int'(vld_s), 0);
        end
        drive(1'b1, 1'b1, 1'b0, 5, 0);
        tick();
        drive(1'b0, 1'b0, 1'b0, 0, 0);
        chk("post_lat1_valid", int'(vld_s), 0);
        tick();
        chk("post_lat2_valid", int'(vld_s), 1);
        chk("post_acc_sum", int'($signed(sum_s)), 5);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/sadd_pipe.md
SADD_PIPE -- requirements
Module: sadd_pipe

Interface
REQ-001 Parameter DATAWIDTH, default 8: operand/result width in bits (>=2).
REQ-002 Parameter LATENCY, default 2: cycles from in_valid sample to out_valid (1..4).
REQ-003 Parameter SATURATE, default 1: 1 = clamp on overflow; 0 = two's-complement wrap.
REQ-004 Clk  input  1  single clock; all state updates on rising edge.
REQ-005 Rst  input  1  asynchronous, active-high reset.
REQ-006 a  input  DATAWIDTH  signed operand A.
REQ-007 b  input  DATAWIDTH  signed operand B (ignored in accumulate mode).
REQ-008 mode  input  1  0 = add (a+b), 1 = accumulate (acc+a).
REQ-009 clr  input  1  synchronous accumulator clear.
REQ-010 in_valid  input  1  operands/mode/clr qualify this cycle.
REQ-011 sum  output  DATAWIDTH  signed result, registered.
REQ-012 out_valid  output  1  sum/ovf valid this cycle.
REQ-013 ovf  output  1  overflow flag of the result on sum.
REQ-014 ovf_sticky  output  1  OR of every ovf since last reset or clr.

Function
REQ-015 Stage 1 SHALL form a DATAWIDTH+1-bit signed sum of the operand pair: (a,b) in add mode, (acc,a) in accumulate mode.
REQ-016 Overflow SHALL be flagged when the full-precision sum lies outside [-2^(DATAWIDTH-1), 2^(DATAWIDTH-1)-1].
REQ-017 SATURATE=1: overflowed result SHALL be 2^(DATAWIDTH-1)-1 if positive, -2^(DATAWIDTH-1) if negative; SATURATE=0: low DATAWIDTH bits.
REQ-018 Internal register acc (DATAWIDTH, signed) SHALL load the clipped stage-1 result on each cycle with in_valid=1 and mode=1; otherwise acc holds.
REQ-019 clr=1 with in_valid=0 SHALL set acc to 0 next cycle.
REQ-020 clr=1 with in_valid=1, mode=1 SHALL use 0 as acc operand (result = a, clipped), acc loads that result.
REQ-021 clr=1 with in_valid=1, mode=0 SHALL clear acc to 0 and process a+b normally.
REQ-022 Accumulator feedback SHALL be single-cycle: back-to-back accumulate transactions each see the acc value updated by the previous one.
REQ-023 Result, ovf and valid SHALL pass through LATENCY register stages total (stage 1 included); out_valid asserts exactly LATENCY cycles after the in_valid edge sample.
REQ-024 Pipeline SHALL have no back-pressure; one transaction per cycle accepted, bubbles (in_valid=0) propagate as out_valid=0.
REQ-025 Stage data registers SHALL load only when their valid bit is set; sum and ovf hold last valid values during bubbles.
REQ-026 ovf_sticky SHALL set the cycle ovf is presented with out_valid=1 and clear on clr=1 (clr has priority on the same cycle).
REQ-027 Mode changes between consecutive transactions SHALL not affect in-flight results; acc is retained across add-mode transactions.

Reset
REQ-028 Rst=1 SHALL immediately clear acc, all stage registers, sum=0, out_valid=0, ovf=0, ovf_sticky=0, independent of Clk.
REQ-029 Transactions in flight at reset SHALL be discarded; first in_valid after Rst deasserts produces out_valid LATENCY cycles later.

Verification (DATAWIDTH=8, LATENCY=2, SATURATE=1 unless stated)
REQ-030 Add: a=100,b=27 -> sum=127, ovf=0 two cycles later; a=100,b=28 -> sum=127, ovf=1; SATURATE=0 same stimulus -> sum=-128, ovf=1.
REQ-031 Negative edge: a=-100,b=-28 -> sum=-128, ovf=0; a=-100,b=-29 -> sum=-128, ovf=1, ovf_sticky=1.
REQ-032 Accumulate: clr pulse, then mode=1, a=10 for 5 consecutive valid cycles -> sum 10,20,30,40,50 on 5 consecutive cycles, out_valid held high.
REQ-033 Accumulate saturation: acc=120, a=10 -> sum=127, ovf=1; next a=-7 -> sum=120, ovf=0, ovf_sticky stays 1 until clr.
REQ-034 Bubbles: in_valid pattern 1,0,1,1 -> out_valid 1,0,1,1 delayed 2 cycles, sum holds through the bubble.
REQ-035 Reset mid-operation: Rst asserted between clock edges with two valid transactions in flight -> sum=0, out_valid=0, acc=0 before next edge; no stale out_valid after release.
